lc3_mem_bridge: RTL and testbench
=================================

// Module: lc3_mem_bridge
// PURPOSE
// - Memory/MMIO stage directly downstream of the LC-3 control FSM. Consumes Mem_CE/Mem_OE/Mem_WE, MAR and MDR.
// - Serves on-chip word RAM plus one memory-mapped port at 0xFFFF: read = switches, write = hex display register.
// - Timing matches the control FSM: OE or WE is held low for exactly 2 cycles per access. MDR loads in the 2nd OE cycle.
// PARAMETERS
// - ADDR_W   10   RAM address bits (2**ADDR_W words, 16 bits each).
// - IO_ADDR  16'hFFFF   MMIO address (switch read / hex write).
// PORTS
// - Clk       in   1   clock; all state updates on posedge.
// - Reset     in   1   synchronous, active-high.
// - Mem_CE    in   1   chip enable, active-low; high = bus ignored.
// - Mem_OE    in   1   read strobe, active-low.
// - Mem_WE    in   1   write strobe, active-low.
// - ADDR      in   16  word address (MAR).
// - Data_in   in   16  write data (MDR).
// - Switches  in   16  asynchronous board switches.
// - Data_out  out  16  read data to MDR mux.
// - HEX_reg   out  16  hex display register.
// - Bus_err   out  1   sticky protocol-error flag.
// BEHAVIOUR
// Reset
// - State=IDLE, Data_out=0, HEX_reg=0, Bus_err=0, switch synchroniser=0.
// - RAM contents are not reset.
// - Reset mid-access: the access is discarded and no RAM/HEX write occurs.
// Switch synchroniser
// - Switches pass through a 2-flop synchroniser: sw_s = Switches delayed by 2 clocks.
// Address decode
// - ADDR==IO_ADDR selects IO.
// - Otherwise RAM index = ADDR[ADDR_W-1:0]. Upper bits are ignored (aliasing).
// FSM states: IDLE, RD, WR1, WR2.
// IDLE
// - Mem_CE=1: no action.
// - Mem_CE=0, OE=0, WE=0: Bus_err<=1, no access, stay IDLE.
// - Mem_CE=0, OE=0, WE=1: rdata_q <= IO ? sw_s : ram[idx]; go RD.
// - Mem_CE=0, WE=0, OE=1: latch addr/data into wa_q/wd_q; go WR1.
// RD
// - Data_out = rdata_q, valid for the whole state. Latency: valid in the 2nd OE-low cycle.
// - rdata_q is frozen for the whole state; ADDR changes are ignored.
// - Stay in RD while OE=0 and CE=0. Otherwise go IDLE.
// WR1
// - WE=0 and CE=0: commit at this edge (the end of the 2nd WE-low cycle).
//   - IO: HEX_reg <= wd_q.
//   - RAM: ram[wa_q] <= wd_q.
//   - Go WR2.
// - WE=1 or CE=1 (strobe 1 cycle short): no write, Bus_err<=1, go IDLE.
// - OE=0 while in WR1: Bus_err<=1; the write still follows the WE rules.
// WR2
// - Stay while WE=0 and CE=0; no further writes (exactly one commit per strobe).
// - WE=1: go IDLE.
// Data_out
// - Holds rdata_q in all states; keeps the last read value outside RD.
// Bus_err
// - Set only by the error cases above.
// - Cleared only by Reset.
// TESTING
// - Write RAM: ADDR=0x0005, Data_in=0xBEEF, WE low 2 cycles -> exactly one write.
//   Then OE low 2 cycles at 0x0005 -> Data_out=0xBEEF in the 2nd OE cycle.
// - MMIO write: WE low 2 cycles at 0xFFFF, Data_in=0x1234 -> HEX_reg=0x1234 after the 2nd edge; RAM[0x3FF] unchanged.
// - MMIO read: Switches=0x00A5, held >=2 cycles -> OE read at 0xFFFF gives Data_out=0x00A5 in the 2nd cycle.
// - Alias: write 0x0400 with 0x7777 at ADDR_W=10 -> read of 0x0000 returns 0x7777.
// - Short write (WE low 1 cycle) -> no RAM change, Bus_err=1.
//   OE and WE low together -> Bus_err=1.
//   Reset -> Bus_err=0.
// - Reset asserted in WR1 -> no write to target; HEX_reg=0; state IDLE; the next read behaves normally.

Source files
------------

// File: rtl/lc3_mem_bridge.sv
// lc3_mem_bridge: LC-3 memory stage serving word RAM plus a switch/hex MMIO port,
// driven by the control FSM's two-cycle active-low OE/WE strobes.
module lc3_mem_bridge #(
   parameter int          ADDR_W  = 10,
   parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_CE,
   input  logic        Mem_OE,
   input  logic        Mem_WE,
   input  logic [15:0] ADDR,
   input  logic [15:0] Data_in,
   input  logic [15:0] Switches,
   output logic [15:0] Data_out,
   output logic [15:0] HEX_reg,
   output logic        Bus_err
);
   typedef enum logic [1:0] {IDLE, RD, WR1, WR2} state_t;
   state_t      state_q, state_d;
   logic [15:0] rdata_q, rdata_d, wa_q, wa_d, wd_q, wd_d, hex_q, hex_d;
   logic [15:0] sw1_q, sw_s_q;
   logic        err_q, err_d, ram_we;
   logic [15:0] ram [0:(1<<ADDR_W)-1];

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      wa_d    = wa_q;
      wd_d    = wd_q;
      hex_d   = hex_q;
      err_d   = err_q;
      ram_we  = 1'b0;
      case (state_q)
         IDLE: if (!Mem_CE) begin
            if (!Mem_OE && !Mem_WE) err_d = 1'b1;
            else if (!Mem_OE) begin
               rdata_d = (ADDR == IO_ADDR) ? sw_s_q : ram[ADDR[ADDR_W-1:0]];
               state_d = RD;
            end else if (!Mem_WE) begin
               wa_d    = ADDR;
               wd_d    = Data_in;
               state_d = WR1;
            end
         end
         RD:  state_d = (!Mem_OE && !Mem_CE) ? RD : IDLE;
         WR1: begin
            if (!Mem_OE) err_d = 1'b1;
            // Commit only once the strobe has been low for its full second cycle
            if (!Mem_WE && !Mem_CE) begin
               state_d = WR2;
               if (wa_q == IO_ADDR) hex_d = wd_q;
               else ram_we = 1'b1;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         WR2: state_d = (!Mem_WE && !Mem_CE) ? WR2 : IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         rdata_q <= '0;
         wa_q    <= '0;
         wd_q    <= '0;
         hex_q   <= '0;
         err_q   <= 1'b0;
         sw1_q   <= '0;
         sw_s_q  <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
         hex_q   <= hex_d;
         err_q   <= err_d;
         sw1_q   <= Switches;
         sw_s_q  <= sw1_q;
      end
   end

   always_ff @(posedge Clk)
      if (ram_we && !Reset) ram[wa_q[ADDR_W-1:0]] <= wd_q;

   assign Data_out = rdata_q;
   assign HEX_reg  = hex_q;
   assign Bus_err  = err_q;
endmodule

// File: tb/tb_lc3_mem_bridge.sv
// tb_lc3_mem_bridge: transaction-level model of RAM/MMIO/error effects, checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_lc3_mem_bridge;
   localparam logic [15:0] IO = 16'hFFFF;
   logic        Clk = 1'b0, Reset, Mem_CE, Mem_OE, Mem_WE;
   logic [15:0] ADDR, Data_in, Switches, Data_out, HEX_reg;
   logic        Bus_err;
   logic [15:0] mem_m [0:1023];
   logic [15:0] exp_do, exp_hex;
   logic        exp_err;
   logic        run = 1'b0;
   int          n_chk = 0, n_fail = 0;

   lc3_mem_bridge dut (
      .Clk(Clk), .Reset(Reset), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .ADDR(ADDR), .Data_in(Data_in), .Switches(Switches),
      .Data_out(Data_out), .HEX_reg(HEX_reg), .Bus_err(Bus_err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) if (run) begin
      chk("data_out", Data_out, exp_do);
      chk("hex_reg", HEX_reg, exp_hex);
      chk("bus_err", {15'd0, Bus_err}, {15'd0, exp_err});
   end

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_bus;
      Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input int n, input bit glitch);
      Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1; ADDR = a; Data_in = d;
      tick;
      for (int i = 2; i <= n; i++) begin
         ADDR = 16'($urandom); Data_in = 16'($urandom);
         Mem_OE = !(glitch && i == 2);
         tick;
         if (i == 2) begin
            if (a == IO) exp_hex = d;
            else mem_m[a[9:0]] = d;
            if (glitch) exp_err = 1'b1;
         end
      end
      idle_bus; ADDR = 16'($urandom);
      tick;
      if (n == 1) exp_err = 1'b1;
      tick;
   endtask

   task automatic rd(input logic [15:0] a, input int n, input logic [15:0] sw);
      Switches = sw;
      tick;
      tick;
      Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = a;
      tick;
      exp_do = (a == IO) ? sw : mem_m[a[9:0]];
      for (int i = 2; i <= n; i++) begin
         ADDR = 16'($urandom);
         tick;
      end
      idle_bus;
      tick;
   endtask

   task automatic both_low;
      Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
      tick;
      exp_err = 1'b1;
      idle_bus;
      tick;
   endtask

   task automatic do_reset;
      Reset = 1'b1;
      tick;
      exp_do = '0; exp_hex = '0; exp_err = 1'b0;
      Reset = 1'b0;
      tick;
   endtask

   task automatic rst_in_wr1(input logic [15:0] a, input logic [15:0] d);
      Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b1; ADDR = a; Data_in = d;
      tick;
      Reset = 1'b1;
      tick;
      exp_do = '0; exp_hex = '0; exp_err = 1'b0;
      Reset = 1'b0; idle_bus;
      tick;
   endtask

   function automatic logic [15:0] rnd_addr();
      logic [9:0] base;
      if ($urandom_range(0, 9) == 0) return IO;
      base = $urandom_range(0, 1) ? 10'h3F8 : 10'h000;
      return {6'($urandom), base + 10'($urandom_range(0, 7))};
   endfunction

   initial begin
      Reset = 1'b1; idle_bus; ADDR = '0; Data_in = '0; Switches = '0;
      tick;
      tick;
      Reset = 1'b0;
      exp_do = '0; exp_hex = '0; exp_err = 1'b0;
      run = 1'b1;
      chk("reset_data_out", Data_out, 16'h0000);
      chk("reset_hex", HEX_reg, 16'h0000);
      chk("reset_err", {15'd0, Bus_err}, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         wr(16'(k), 16'($urandom), 2, 1'b0);
         wr(16'(10'h3F8 + k), 16'($urandom), 2, 1'b0);
      end
      wr(16'h0005, 16'hBEEF, 2, 1'b0);
      rd(16'h0005, 2, 16'h0);
      chk("ram_write_read", Data_out, 16'hBEEF);
      wr(16'h03FF, 16'hCAFE, 2, 1'b0);
      wr(IO, 16'h1234, 2, 1'b0);
      chk("mmio_hex_write", HEX_reg, 16'h1234);
      rd(16'h03FF, 3, 16'h0);
      chk("ram_3ff_untouched", Data_out, 16'hCAFE);
      rd(IO, 2, 16'h00A5);
      chk("mmio_switch_read", Data_out, 16'h00A5);
      wr(16'h0400, 16'h7777, 2, 1'b0);
      rd(16'h0000, 2, 16'h0);
      chk("alias_read", Data_out, 16'h7777);
      chk("err_clear_before_short", {15'd0, Bus_err}, 16'h0000);
      wr(16'h0005, 16'h1111, 1, 1'b0);
      chk("short_write_err", {15'd0, Bus_err}, 16'h0001);
      rd(16'h0005, 2, 16'h0);
      chk("short_write_no_change", Data_out, 16'hBEEF);
      do_reset;
      chk("reset_clears_err", {15'd0, Bus_err}, 16'h0000);
      both_low;
      chk("oe_we_both_err", {15'd0, Bus_err}, 16'h0001);
      do_reset;
      wr(IO, 16'h4321, 3, 1'b0);
      rst_in_wr1(IO, 16'h5555);
      chk("rst_wr1_hex", HEX_reg, 16'h0000);
      rst_in_wr1(16'h0005, 16'hAAAA);
      rd(16'h0005, 2, 16'h0);
      chk("rst_wr1_no_ram_write", Data_out, 16'hBEEF);
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: wr(rnd_addr(), 16'($urandom), $urandom_range(1, 4), $urandom_range(0, 4) == 0);
            4, 5, 6, 7: rd(rnd_addr(), $urandom_range(1, 4), 16'($urandom));
            8:          both_low;
            default:    if ($urandom_range(0, 1) != 0) do_reset;
                        else rst_in_wr1(rnd_addr(), 16'($urandom));
         endcase
      end
      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
